mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge; reset  in  1  asynchronous, active-high.
REQ-002 SHALL have ports: ex_valid  in  1  ex_data holds a live instruction; ex_data  in  execute_data_t  execute-stage result (instr, aluout = effective address, writedata = store data, writereg, hi, lo, pcplus4, in_delay_slot, exception flags); flush  in  1  squash the in-flight instruction.
REQ-003 SHALL have data-bus ports: dreq  out  dbus_req_t  {valid, addr[31:0], size[1:0], strobe[3:0], data[31:0]}; dresp  in  dbus_resp_t  {addr_ok, data_ok, data[31:0]}.
REQ-004 SHALL have outputs: mem_stall  out  1  upstream hold; mem_valid  out  1  mem_data live; mem_data  out  memory_data_t  registered stage result.

Function
REQ-005 SHALL treat an instruction as a memory op when instr.mem_read or instr.mem_write is set; size from instr.mem_size (0 byte, 1 half, 2 word), sign from instr.mem_signed.
REQ-006 SHALL flag misalignment (word: addr[1:0]!=0; half: addr[0]!=0), issue no bus request, set exception_adel (load) or exception_ades (store) and badvaddr = aluout in mem_data.
REQ-007 SHALL use FSM states IDLE, WAIT_ADDR, WAIT_DATA, DRAIN.
REQ-008 IDLE, ex_valid, aligned memory op, no flush: drive dreq.valid combinationally same cycle; addr_ok&data_ok -> result captured, stay IDLE; addr_ok only -> WAIT_DATA; neither -> WAIT_ADDR.
REQ-009 WAIT_ADDR SHALL hold dreq.valid and all dreq fields stable until addr_ok; transitions as in REQ-008.
REQ-010 WAIT_DATA SHALL drive dreq.valid=0; on data_ok capture result, go IDLE.
REQ-011 flush in WAIT_ADDR SHALL keep request until addr_ok, then go DRAIN (or IDLE if data_ok same cycle); flush in WAIT_DATA SHALL go DRAIN; DRAIN discards data on data_ok and goes IDLE; no mem_valid produced for a flushed op.
REQ-012 flush in IDLE SHALL suppress request and capture nothing.
REQ-013 mem_stall SHALL be 1 whenever the op in ex_data has not completed this cycle (REQ-008 without data_ok, WAIT_ADDR, WAIT_DATA) and in DRAIN; 0 otherwise.
REQ-014 Store: strobe byte 4'b0001<<addr[1:0], half 4'b0011<<addr[1:0], word 4'b1111; data = writedata byte/half replicated across lanes; dreq.addr = aluout.
REQ-015 Load: shift dresp.data right by 8*addr[1:0], sign- or zero-extend per mem_signed into mem_data.readdata.
REQ-016 Non-memory or misaligned instruction with ex_valid and no flush SHALL pass to mem_data with exactly 1-cycle latency, mem_stall=0.
REQ-017 mem_valid SHALL be a one-cycle pulse per completed instruction, asserted the cycle after completion; mem_data holds its value until the next capture.
REQ-018 Memory op latency SHALL be 1 cycle after data_ok; minimum 1 cycle when addr_ok and data_ok arrive with the request.

Reset
REQ-019 reset SHALL asynchronously force state=IDLE, mem_valid=0, mem_data=0, dreq.valid=0, mem_stall=0.
REQ-020 reset mid-transaction SHALL abandon the access; no late data_ok is consumed after reset release.

Structure
REQ-021 memory_data_t (instr, readdata, aluout, writereg, hi, lo, pcplus4, in_delay_slot, exception flags incl. adel/ades, badvaddr) and the FSM state enum SHALL live in shared package memory_pkg importing execute_pkg.
REQ-022 Store-lane formatting and load extraction SHALL be one combinational sub-module, mem_align.

Verification
REQ-023 LW addr 0x100, addr_ok+data_ok same cycle, data 0xDEADBEEF -> mem_valid next cycle, readdata 0xDEADBEEF, stall never high after request cycle.
REQ-024 LB signed addr 0x103, data 0x80112233, addr_ok after 2 cycles, data_ok 3 cycles later -> readdata 0xFFFFFF80, strobe unused, stall high through wait.
REQ-025 SH addr 0x102, writedata 0x0000ABCD -> strobe 4'b1100, dreq.data 0xABCDABCD, size 1.
REQ-026 LW addr 0x101 -> no dreq.valid, exception_adel=1, badvaddr 0x101, mem_valid after 1 cycle.
REQ-027 LW issued, addr_ok, flush in WAIT_DATA, data_ok 2 cycles later -> no mem_valid, FSM back to IDLE, next ADD passes in 1 cycle.
REQ-028 reset asserted in WAIT_ADDR -> dreq.valid=0, mem_valid=0 immediately, IDLE after release.

Source files
------------

// File: rtl/execute_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// execute_pkg : execute-stage result types consumed by the memory stage.
// Rev 1.0
// ---------------------------------------------------------------------------
package execute_pkg;

  typedef struct packed {
    logic [5:0] op;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_size;
    logic       mem_signed;
  } instr_t;

  typedef struct packed {
    instr_t      instr;
    logic [31:0] aluout;
    logic [31:0] writedata;
    logic [4:0]  writereg;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] pcplus4;
    logic        in_delay_slot;
    logic        exception_ov;
    logic        exception_ri;
  } execute_data_t;

endpackage
`default_nettype wire

// File: rtl/memory_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// memory_pkg : memory-stage result, data-bus types and FSM states.
// Rev 1.0
// ---------------------------------------------------------------------------
package memory_pkg;
  import execute_pkg::*;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
  localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
  localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {IDLE, WAIT_ADDR, WAIT_DATA, DRAIN} mem_state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

  typedef struct packed {
    instr_t      instr;
    logic [31:0] readdata;
    logic [31:0] aluout;
    logic [4:0]  writereg;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] pcplus4;
    logic        in_delay_slot;
    logic        exception_ov;
    logic        exception_ri;
    logic        exception_adel;
    logic        exception_ades;
    logic [31:0] badvaddr;
  } memory_data_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr);
    case (size)
      MEM_SIZE_BYTE: return 1'b0;
      MEM_SIZE_HALF: return addr[0];
      default:       return addr != 2'b00;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_access_if : data-bus request/response bundle.
// Rev 1.0
// ---------------------------------------------------------------------------
interface mem_access_if;
  memory_pkg::dbus_req_t  dreq;
  memory_pkg::dbus_resp_t dresp;

  modport master (output dreq, input dresp);
  modport slave  (input dreq, output dresp);
endinterface
`default_nettype wire

// File: rtl/mem_align.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_align : store-lane replication/strobes and load extraction.
// Rev 1.0
// ---------------------------------------------------------------------------
module mem_align
  import memory_pkg::*;
(
  input  logic [1:0]  i_addr,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_strobe,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [31:0] w_shifted;

  assign w_shifted = i_rdata >> {i_addr, 3'b000};

  always_comb begin
    o_strobe = 4'b1111;
    o_wdata  = i_wdata;
    o_rdata  = w_shifted;
    case (i_size)
      MEM_SIZE_BYTE: begin
        o_strobe = 4'b0001 << i_addr;
        o_wdata  = {4{i_wdata[7:0]}};
        o_rdata  = {{24{i_signed & w_shifted[7]}}, w_shifted[7:0]};
      end
      MEM_SIZE_HALF: begin
        o_strobe = 4'b0011 << i_addr;
        o_wdata  = {2{i_wdata[15:0]}};
        o_rdata  = {{16{i_signed & w_shifted[15]}}, w_shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_access : pipeline memory stage driving a split addr/data handshake bus.
// Rev 1.0
// ---------------------------------------------------------------------------
module mem_access
  import execute_pkg::*;
  import memory_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          i_ex_valid,
  input  execute_data_t i_ex_data,
  input  logic          i_flush,
  mem_access_if.master  dbus,
  output logic          o_mem_stall,
  output logic          o_mem_valid,
  output memory_data_t  o_mem_data
);

  mem_state_e    r_state, w_next;
  execute_data_t r_ex;
  logic          r_flushed;
  logic          r_mem_valid;
  memory_data_t  r_mem_data;

  execute_data_t w_cur;
  logic          w_is_mem, w_misalign, w_kill;
  logic          w_req_valid, w_complete, w_stall, w_capture_ex;
  logic [3:0]    w_strobe;
  logic [31:0]   w_wdata, w_rdata;
  memory_data_t  w_result;

  // Once a request is outstanding, the registered copy drives the bus so the
  // fields stay stable even if upstream changes ex_data (e.g. after a flush).
  assign w_cur      = (r_state == IDLE) ? i_ex_data : r_ex;
  assign w_is_mem   = w_cur.instr.mem_read | w_cur.instr.mem_write;
  assign w_misalign = w_is_mem & is_misaligned(w_cur.instr.mem_size, w_cur.aluout[1:0]);
  assign w_kill     = i_flush | r_flushed;

  mem_align u_align (
    .i_addr   (w_cur.aluout[1:0]),
    .i_size   (w_cur.instr.mem_size),
    .i_signed (w_cur.instr.mem_signed),
    .i_wdata  (w_cur.writedata),
    .i_rdata  (dbus.dresp.data),
    .o_strobe (w_strobe),
    .o_wdata  (w_wdata),
    .o_rdata  (w_rdata)
  );

  always_comb begin
    w_next       = r_state;
    w_req_valid  = 1'b0;
    w_complete   = 1'b0;
    w_stall      = 1'b0;
    w_capture_ex = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_ex_valid && !i_flush) begin
          if (w_is_mem && !w_misalign) begin
            w_req_valid  = 1'b1;
            w_capture_ex = 1'b1;
            if (dbus.dresp.addr_ok && dbus.dresp.data_ok) begin
              w_complete = 1'b1;
            end else begin
              w_stall = 1'b1;
              w_next  = dbus.dresp.addr_ok ? WAIT_DATA : WAIT_ADDR;
            end
          end else begin
            w_complete = 1'b1;
          end
        end
      end
      WAIT_ADDR: begin
        w_req_valid = 1'b1;
        w_stall     = 1'b1;
        if (dbus.dresp.addr_ok) begin
          if (dbus.dresp.data_ok) begin
            w_stall    = 1'b0;
            w_complete = !w_kill;
            w_next     = IDLE;
          end else begin
            w_next = w_kill ? DRAIN : WAIT_DATA;
          end
        end
      end
      WAIT_DATA: begin
        w_stall = 1'b1;
        if (dbus.dresp.data_ok) begin
          w_stall    = 1'b0;
          w_complete = !i_flush;
          w_next     = IDLE;
        end else if (i_flush) begin
          w_next = DRAIN;
        end
      end
      DRAIN: begin
        w_stall = 1'b1;
        if (dbus.dresp.data_ok) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_result                = '0;
    w_result.instr          = w_cur.instr;
    w_result.readdata       = (w_cur.instr.mem_read && !w_misalign) ? w_rdata : 32'd0;
    w_result.aluout         = w_cur.aluout;
    w_result.writereg       = w_cur.writereg;
    w_result.hi             = w_cur.hi;
    w_result.lo             = w_cur.lo;
    w_result.pcplus4        = w_cur.pcplus4;
    w_result.in_delay_slot  = w_cur.in_delay_slot;
    w_result.exception_ov   = w_cur.exception_ov;
    w_result.exception_ri   = w_cur.exception_ri;
    w_result.exception_adel = w_misalign & w_cur.instr.mem_read;
    w_result.exception_ades = w_misalign & w_cur.instr.mem_write & !w_cur.instr.mem_read;
    w_result.badvaddr       = w_misalign ? w_cur.aluout : 32'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_ex        <= '0;
      r_flushed   <= 1'b0;
      r_mem_valid <= 1'b0;
      r_mem_data  <= '0;
    end else begin
      r_state     <= w_next;
      r_flushed   <= (r_state == WAIT_ADDR) && (w_next == WAIT_ADDR) && w_kill;
      r_mem_valid <= w_complete;
      if (w_capture_ex) r_ex <= i_ex_data;
      if (w_complete)   r_mem_data <= w_result;
    end
  end

  // Combinational outputs are gated so an asserted reset silences them at once.
  assign dbus.dreq.valid  = w_req_valid & !reset;
  assign dbus.dreq.addr   = w_cur.aluout;
  assign dbus.dreq.size   = w_cur.instr.mem_size;
  assign dbus.dreq.strobe = w_cur.instr.mem_write ? w_strobe : 4'b0000;
  assign dbus.dreq.data   = w_wdata;

  assign o_mem_stall = w_stall & !reset;
  assign o_mem_valid = r_mem_valid;
  assign o_mem_data  = r_mem_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_access : directed self-checking bench for mem_access.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_mem_access;
  import execute_pkg::*;
  import memory_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic          ex_valid;
  execute_data_t ex_data;
  logic          flush;
  logic          mem_stall;
  logic          mem_valid;
  memory_data_t  mem_data;
  int            n_tests = 0;
  int            n_fail  = 0;

  mem_access_if dbus();

  mem_access dut (
    .clk         (clk),
    .reset       (reset),
    .i_ex_valid  (ex_valid),
    .i_ex_data   (ex_data),
    .i_flush     (flush),
    .dbus        (dbus.master),
    .o_mem_stall (mem_stall),
    .o_mem_valid (mem_valid),
    .o_mem_data  (mem_data)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LB  = 6'h20 + 6'h0;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  function automatic execute_data_t mk(input logic [5:0] op, input logic rd, input logic wr,
                                       input logic [1:0] sz, input logic sg,
                                       input logic [31:0] addr, input logic [31:0] wd);
    execute_data_t e;
    e = '0;
    e.instr.op         = op;
    e.instr.reg_write  = !wr;
    e.instr.mem_read   = rd;
    e.instr.mem_write  = wr;
    e.instr.mem_size   = sz;
    e.instr.mem_signed = sg;
    e.aluout           = addr;
    e.writedata        = wd;
    e.writereg         = 5'd9;
    e.pcplus4          = 32'hBFC0_0104;
    return e;
  endfunction

  task automatic set_resp(input logic a, input logic d, input logic [31:0] dat);
    dbus.dresp.addr_ok = a;
    dbus.dresp.data_ok = d;
    dbus.dresp.data    = dat;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0;
    ex_valid = 1'b1; ex_data = mk(OP_LW, 1, 0, MEM_SIZE_WORD, 0, 32'h100, 0);
    set_resp(1, 1, 32'h1234_5678);
    #2;
    n_tests++; if (dbus.dreq.valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid: got %b want 0", dbus.dreq.valid); end
    n_tests++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", mem_stall); end
    step();
    n_tests++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mem_valid: got %b want 0", mem_valid); end
    n_tests++; if (mem_data !== '0) begin n_fail++; $display("FAIL rst_mem_data: got %h want 0", mem_data); end
    ex_valid = 1'b0; set_resp(0, 0, 0);
    reset = 1'b0;
    step();
  endtask

  task automatic test_lw_fast();
    ex_valid = 1'b1; ex_data = mk(OP_LW, 1, 0, MEM_SIZE_WORD, 0, 32'h100, 0);
    set_resp(1, 1, 32'hDEAD_BEEF);
    #1;
    n_tests++; if (dbus.dreq.valid !== 1'b1) begin n_fail++; $display("FAIL lw_req_valid: got %b want 1", dbus.dreq.valid); end
    n_tests++; if (dbus.dreq.addr !== 32'h100) begin n_fail++; $display("FAIL lw_addr: got %h want 100", dbus.dreq.addr); end
    n_tests++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL lw_stall: got %b want 0", mem_stall); end
    step();
    ex_valid = 1'b0; set_resp(0, 0, 0);
    #1;
    n_tests++; if (mem_valid !== 1'b1) begin n_fail++; $display("FAIL lw_mem_valid: got %b want 1", mem_valid); end
    n_tests++; if (mem_data.readdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_rdata: got %h want deadbeef", mem_data.readdata); end
    n_tests++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL lw_stall_after: got %b want 0", mem_stall); end
    step();
    n_tests++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL lw_pulse: got %b want 0", mem_valid); end
    n_tests++; if (mem_data.readdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_hold: got %h want deadbeef", mem_data.readdata); end
  endtask

  task automatic test_lb_wait();
    ex_valid = 1'b1; ex_data = mk(OP_LB, 1, 0, MEM_SIZE_BYTE, 1, 32'h103, 0);
    for (int c = 0; c < 6; c++) begin
      set_resp(c == 2, c == 5, (c == 5) ? 32'h8011_2233 : 32'h0);
      #1;
      n_tests++; if (mem_stall !== (c != 5)) begin n_fail++; $display("FAIL lb_stall c%0d: got %b want %b", c, mem_stall, c != 5); end
      n_tests++; if (dbus.dreq.valid !== (c <= 2)) begin n_fail++; $display("FAIL lb_req_valid c%0d: got %b want %b", c, dbus.dreq.valid, c <= 2); end
      if (c <= 2) begin
        n_tests++; if (dbus.dreq.addr !== 32'h103 || dbus.dreq.strobe !== 4'b0000) begin n_fail++; $display("FAIL lb_req c%0d: got %h/%b want 103/0000", c, dbus.dreq.addr, dbus.dreq.strobe); end
      end
      if (c > 0) begin
        n_tests++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL lb_early_valid c%0d: got %b want 0", c, mem_valid); end
      end
      step();
    end
    ex_valid = 1'b0; set_resp(0, 0, 0);
    #1;
    n_tests++; if (mem_valid !== 1'b1) begin n_fail++; $display("FAIL lb_mem_valid: got %b want 1", mem_valid); end
    n_tests++; if (mem_data.readdata !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_rdata: got %h want ffffff80", mem_data.readdata); end
    step();
  endtask

  task automatic test_sh_store();
    ex_valid = 1'b1; ex_data = mk(OP_SH, 0, 1, MEM_SIZE_HALF, 0, 32'h102, 32'h0000_ABCD);
    set_resp(1, 1, 32'h5555_5555);
    #1;
    n_tests++; if (dbus.dreq.strobe !== 4'b1100) begin n_fail++; $display("FAIL sh_strobe: got %b want 1100", dbus.dreq.strobe); end
    n_tests++; if (dbus.dreq.data !== 32'hABCD_ABCD) begin n_fail++; $display("FAIL sh_data: got %h want abcdabcd", dbus.dreq.data); end
    n_tests++; if (dbus.dreq.size !== 2'd1) begin n_fail++; $display("FAIL sh_size: got %0d want 1", dbus.dreq.size); end
    n_tests++; if (dbus.dreq.valid !== 1'b1) begin n_fail++; $display("FAIL sh_req_valid: got %b want 1", dbus.dreq.valid); end
    step();
    ex_valid = 1'b0; set_resp(0, 0, 0);
    #1;
    n_tests++; if (mem_valid !== 1'b1 || mem_data.exception_ades !== 1'b0) begin n_fail++; $display("FAIL sh_done: got v%b ades%b want v1 ades0", mem_valid, mem_data.exception_ades); end
    step();
  endtask

  task automatic test_misaligned();
    ex_valid = 1'b1; ex_data = mk(OP_LW, 1, 0, MEM_SIZE_WORD, 0, 32'h101, 0);
    #1;
    n_tests++; if (dbus.dreq.valid !== 1'b0) begin n_fail++; $display("FAIL adel_req_valid: got %b want 0", dbus.dreq.valid); end
    n_tests++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL adel_stall: got %b want 0", mem_stall); end
    step();
    ex_data = mk(OP_SW, 0, 1, MEM_SIZE_WORD, 0, 32'h202, 32'h1);
    #1;
    n_tests++; if (mem_valid !== 1'b1) begin n_fail++; $display("FAIL adel_mem_valid: got %b want 1", mem_valid); end
    n_tests++; if (mem_data.exception_adel !== 1'b1 || mem_data.exception_ades !== 1'b0) begin n_fail++; $display("FAIL adel_flags: got adel%b ades%b want 1/0", mem_data.exception_adel, mem_data.exception_ades); end
    n_tests++; if (mem_data.badvaddr !== 32'h101) begin n_fail++; $display("FAIL adel_badvaddr: got %h want 101", mem_data.badvaddr); end
    step();
    ex_valid = 1'b0;
    #1;
    n_tests++; if (mem_data.exception_ades !== 1'b1 || mem_data.badvaddr !== 32'h202) begin n_fail++; $display("FAIL ades: got ades%b bad %h want 1/202", mem_data.exception_ades, mem_data.badvaddr); end
    step();
  endtask

  task automatic test_flush_wait_data();
    int seen;
    seen = 0;
    ex_valid = 1'b1; ex_data = mk(OP_LW, 1, 0, MEM_SIZE_WORD, 0, 32'h200, 0);
    set_resp(1, 0, 0);
    step();
    ex_valid = 1'b0; flush = 1'b1; set_resp(0, 0, 0);
    #1;
    n_tests++; if (mem_stall !== 1'b1) begin n_fail++; $display("FAIL fwd_stall_flush: got %b want 1", mem_stall); end
    seen += int'(mem_valid);
    step();
    flush = 1'b0; set_resp(0, 1, 32'h7777_7777);
    #1;
    n_tests++; if (mem_stall !== 1'b1) begin n_fail++; $display("FAIL fwd_stall_drain: got %b want 1", mem_stall); end
    seen += int'(mem_valid);
    step();
    set_resp(0, 0, 0);
    ex_valid = 1'b1; ex_data = mk(OP_ADD, 0, 0, 2'd0, 0, 32'h0000_0042, 0);
    #1;
    seen += int'(mem_valid);
    n_tests++; if (mem_stall !== 1'b0 || dbus.dreq.valid !== 1'b0) begin n_fail++; $display("FAIL fwd_add_issue: got stall%b req%b want 0/0", mem_stall, dbus.dreq.valid); end
    step();
    ex_valid = 1'b0;
    #1;
    n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL fwd_flushed_valid: got %0d pulses want 0", seen); end
    n_tests++; if (mem_valid !== 1'b1 || mem_data.aluout !== 32'h42 || mem_data.instr.op !== OP_ADD) begin n_fail++; $display("FAIL fwd_add_pass: got v%b alu %h op %h want 1/42/20", mem_valid, mem_data.aluout, mem_data.instr.op); end
    step();
  endtask

  task automatic test_flush_wait_addr();
    int seen;
    seen = 0;
    ex_valid = 1'b1; ex_data = mk(OP_LW, 1, 0, MEM_SIZE_WORD, 0, 32'h400, 0);
    set_resp(0, 0, 0);
    step();
    ex_valid = 1'b0; flush = 1'b1; ex_data = mk(OP_ADD, 0, 0, 2'd0, 0, 32'h999, 0);
    #1;
    n_tests++; if (dbus.dreq.valid !== 1'b1 || dbus.dreq.addr !== 32'h400) begin n_fail++; $display("FAIL fwa_hold: got req%b addr %h want 1/400", dbus.dreq.valid, dbus.dreq.addr); end
    step();
    flush = 1'b0; set_resp(1, 0, 0);
    #1;
    n_tests++; if (dbus.dreq.valid !== 1'b1 || mem_stall !== 1'b1) begin n_fail++; $display("FAIL fwa_accept: got req%b stall%b want 1/1", dbus.dreq.valid, mem_stall); end
    seen += int'(mem_valid);
    step();
    set_resp(0, 1, 32'h1);
    #1;
    n_tests++; if (dbus.dreq.valid !== 1'b0 || mem_stall !== 1'b1) begin n_fail++; $display("FAIL fwa_drain: got req%b stall%b want 0/1", dbus.dreq.valid, mem_stall); end
    seen += int'(mem_valid);
    step();
    set_resp(0, 0, 0);
    #1;
    seen += int'(mem_valid);
    n_tests++; if (mem_stall !== 1'b0 || seen !== 0) begin n_fail++; $display("FAIL fwa_idle: got stall%b pulses %0d want 0/0", mem_stall, seen); end
    step();
  endtask

  task automatic test_flush_idle();
    ex_valid = 1'b1; flush = 1'b1; ex_data = mk(OP_LW, 1, 0, MEM_SIZE_WORD, 0, 32'h500, 0);
    set_resp(1, 1, 32'hAAAA_AAAA);
    #1;
    n_tests++; if (dbus.dreq.valid !== 1'b0 || mem_stall !== 1'b0) begin n_fail++; $display("FAIL fidle_req: got req%b stall%b want 0/0", dbus.dreq.valid, mem_stall); end
    step();
    ex_valid = 1'b0; flush = 1'b0; set_resp(0, 0, 0);
    #1;
    n_tests++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL fidle_valid: got %b want 0", mem_valid); end
    step();
  endtask

  task automatic test_reset_mid();
    ex_valid = 1'b1; ex_data = mk(OP_LW, 1, 0, MEM_SIZE_WORD, 0, 32'h300, 0);
    set_resp(0, 0, 0);
    step();
    #1;
    reset = 1'b1; ex_valid = 1'b0;
    #1;
    n_tests++; if (dbus.dreq.valid !== 1'b0 || mem_valid !== 1'b0 || mem_stall !== 1'b0) begin n_fail++; $display("FAIL rmid_async: got req%b v%b stall%b want 0/0/0", dbus.dreq.valid, mem_valid, mem_stall); end
    step();
    reset = 1'b0; set_resp(0, 1, 32'hBAD0_BAD0);
    #1;
    n_tests++; if (mem_stall !== 1'b0 || dbus.dreq.valid !== 1'b0) begin n_fail++; $display("FAIL rmid_late: got stall%b req%b want 0/0", mem_stall, dbus.dreq.valid); end
    step();
    set_resp(0, 0, 0);
    ex_valid = 1'b1; ex_data = mk(OP_ADD, 0, 0, 2'd0, 0, 32'h77, 0);
    #1;
    n_tests++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_consumed: got %b want 0", mem_valid); end
    step();
    ex_valid = 1'b0;
    #1;
    n_tests++; if (mem_valid !== 1'b1 || mem_data.aluout !== 32'h77) begin n_fail++; $display("FAIL rmid_idle: got v%b alu %h want 1/77", mem_valid, mem_data.aluout); end
    step();
  endtask

  initial begin
    test_reset();
    test_lw_fast();
    test_lb_wait();
    test_sh_store();
    test_misaligned();
    test_flush_wait_data();
    test_flush_wait_addr();
    test_flush_idle();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
